// File: rtl/phi_sequencer_pkg.sv
// Shared types for the phi0 sequencer: FSM state encoding and the registered output bundle.
`timescale 1ns/1ps
package phi_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_PHI1 = 2'd1,
        ST_PHI2 = 2'd2,
        ST_EXT  = 2'd3
    } state_e;

    localparam int CYC_W = 16;

    typedef struct packed {
        logic phi0;
        logic phi0_rise;
        logic phi0_fall;
        logic db_oe;
        logic db_latch;
        logic halted;
        logic step_ack;
    } out_t;

endpackage

// File: rtl/phi_sequencer_edge_detect.sv
// Registered-history edge detector for an already-synchronized level input.
`timescale 1ns/1ps
module edge_detect (
    input  logic eclk,
    input  logic ereset_n,
    input  logic in_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= in_i;
        end
    end

    assign rise_o = in_i && !prev_q;
    assign fall_o = !in_i && prev_q;

endmodule

// File: rtl/phi_sequencer.sv
// phi0 phase generator for chip_6502: internal divider or external clk0, data-bus strobe timing,
// and run / single-step / halt control with a 4-phase step handshake.
`timescale 1ns/1ps
module phi_sequencer
    import phi_sequencer_pkg::*;
#(
    parameter int HALF_CYCLES   = 28,
    parameter int DRIVE_DELAY   = 2,
    parameter int SAMPLE_OFFSET = 4,
    parameter int CNT_W         = 8
) (
    input  logic             eclk,
    input  logic             ereset_n,
    input  logic             run_en,
    input  logic             ext_mode,
    input  logic             ext_clk0,
    input  logic             step_req,
    output logic             step_ack,
    input  logic             rw_in,
    output logic             phi0,
    output logic             phi0_rise,
    output logic             phi0_fall,
    output logic             db_oe,
    output logic             db_latch,
    output logic             halted,
    output logic [CYC_W-1:0] cycle_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_CNT = CNT_W'(DRIVE_DELAY);
    localparam logic [CNT_W-1:0] LATCH_CNT = CNT_W'(HALF_CYCLES - 1 - SAMPLE_OFFSET);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             pend_q, pend_d;
    out_t             out_q, out_d;

    logic ext_rise, ext_fall;
    logic ext_phi, ext_done;

    edge_detect u_ext_edge (
        .eclk     (eclk),
        .ereset_n (ereset_n),
        .in_i     (ext_clk0),
        .rise_o   (ext_rise),
        .fall_o   (ext_fall)
    );

    // phi0 only changes on detected ext edges, so entering EXT while clk0 is already high waits
    // for a clean rise; a fall only completes a cycle if phi0 was actually high.
    assign ext_phi  = out_q.phi0 ? !ext_fall : ext_rise;
    assign ext_done = (state_q == ST_EXT) && out_q.phi0 && ext_fall;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cyc_d          = cyc_q;
        pend_d         = pend_q;
        out_d          = '0;
        out_d.step_ack = out_q.step_ack && step_req;

        case (state_q)
            ST_HALT: begin
                if (run_en || (step_req && !out_q.step_ack)) begin
                    pend_d  = !run_en;
                    cnt_d   = '0;
                    state_d = ext_mode ? ST_EXT : ST_PHI1;
                end
            end
            ST_PHI1: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = ST_PHI2;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PHI2: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    cyc_d   = cyc_q + CYC_W'(1);
                    state_d = run_en ? ST_PHI1 : ST_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EXT: begin
                if (ext_done) begin
                    cyc_d = cyc_q + CYC_W'(1);
                    if (!run_en) begin
                        state_d = ST_HALT;
                    end
                end
            end
            default: state_d = ST_HALT;
        endcase

        // A step is acknowledged only once its full cycle has brought us back to HALT.
        if (state_q != ST_HALT && state_d == ST_HALT && pend_q) begin
            out_d.step_ack = 1'b1;
            pend_d         = 1'b0;
        end

        out_d.phi0      = (state_d == ST_PHI2) || (state_d == ST_EXT && ext_phi);
        out_d.phi0_rise = out_d.phi0 && !out_q.phi0;
        out_d.phi0_fall = !out_d.phi0 && out_q.phi0;
        out_d.db_oe     = !rw_in &&
                          ((state_d == ST_PHI2 && cnt_d >= DRIVE_CNT) ||
                           (state_d == ST_EXT && out_d.phi0 && out_q.phi0));
        out_d.db_latch  = (state_d == ST_PHI2 && cnt_d == LATCH_CNT) || ext_done;
        out_d.halted    = (state_d == ST_HALT);
    end

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            state_q <= ST_HALT;
            cnt_q   <= '0;
            cyc_q   <= '0;
            pend_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
        end
    end

    assign phi0      = out_q.phi0;
    assign phi0_rise = out_q.phi0_rise;
    assign phi0_fall = out_q.phi0_fall;
    assign db_oe     = out_q.db_oe;
    assign db_latch  = out_q.db_latch;
    assign halted    = out_q.halted;
    assign step_ack  = out_q.step_ack;
    assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_phi_sequencer.sv
// Scoreboarded bench for phi_sequencer: each expected phi0 cycle is queued by the stimulus and
// checked by a monitor when the DUT reports phi0_fall.
`timescale 1ns/1ps
module tb_phi_sequencer;

    localparam int HC = 4;
    localparam int DD = 1;
    localparam int SO = 1;

    logic        eclk     = 1'b0;
    logic        ereset_n = 1'b0;
    logic        run_en   = 1'b0;
    logic        ext_mode = 1'b0;
    logic        ext_clk0 = 1'b0;
    logic        step_req = 1'b0;
    logic        rw_in    = 1'b1;
    logic        step_ack, phi0, phi0_rise, phi0_fall, db_oe, db_latch, halted;
    logic [15:0] cycle_cnt;

    phi_sequencer #(
        .HALF_CYCLES   (HC),
        .DRIVE_DELAY   (DD),
        .SAMPLE_OFFSET (SO),
        .CNT_W         (8)
    ) dut (
        .eclk      (eclk),
        .ereset_n  (ereset_n),
        .run_en    (run_en),
        .ext_mode  (ext_mode),
        .ext_clk0  (ext_clk0),
        .step_req  (step_req),
        .step_ack  (step_ack),
        .rw_in     (rw_in),
        .phi0      (phi0),
        .phi0_rise (phi0_rise),
        .phi0_fall (phi0_fall),
        .db_oe     (db_oe),
        .db_latch  (db_latch),
        .halted    (halted),
        .cycle_cnt (cycle_cnt)
    );

    always #5 eclk = ~eclk;

    typedef struct {
        logic [15:0] cnt;
        int          hi;
        int          oe;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hi_n, oe_n, lat_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] cnt, input int hi, input int oe, input int lat);
        exp_t e;
        e.cnt = cnt; e.hi = hi; e.oe = oe; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge eclk);
            #1;
        end
    endtask

    task automatic wait_pulse(input bit want_rise, input int budget, input string name);
        int k;
        k = 0;
        do begin
            step(1);
            k++;
        end while (!(want_rise ? phi0_rise : phi0_fall) && k < budget);
        if (!(want_rise ? phi0_rise : phi0_fall)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no pulse within %0d cycles", name, budget);
        end
    endtask

    // Monitor: accumulate per-cycle activity, compare against the queue on each phi0 fall.
    initial begin
        hi_n = 0; oe_n = 0; lat_n = 0;
        forever begin
            @(negedge eclk);
            if (!ereset_n) begin
                hi_n = 0; oe_n = 0; lat_n = 0;
            end else begin
                if (phi0)     hi_n++;
                if (db_oe)    oe_n++;
                if (db_latch) lat_n++;
                if (phi0_fall) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_fall: cycle_cnt %0h with empty queue", cycle_cnt);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("fall_cycle_cnt", cycle_cnt, mon_e.cnt);
                        check("fall_phi0_high_len", hi_n, mon_e.hi);
                        check("fall_db_oe_len", oe_n, mon_e.oe);
                        check("fall_db_latch_cnt", lat_n, mon_e.lat);
                    end
                    hi_n = 0; oe_n = 0; lat_n = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;

        // Reset state
        step(3);
        check("rst_phi0", phi0, 0);
        check("rst_halted", halted, 0);
        check("rst_step_ack", step_ack, 0);
        check("rst_db_oe", db_oe, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        ereset_n = 1'b1;
        step(1);
        check("halted_after_release", halted, 1);

        // Free run from HALT: phi0 high after edges 5..8, first fall at edge 9
        push(16'd1, HC, 0, 1);
        run_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            check($sformatf("phi0_edge%0d", i), phi0, (i >= 5 && i <= 8));
            if (i == 5) check("phi0_rise_edge5", phi0_rise, 1);
            if (i == 9) check("phi0_fall_edge9", phi0_fall, 1);
        end

        // Writes: db_oe for PHI2 counts 1..3, one latch per cycle; then run_en drops mid-PHI1
        rw_in = 1'b0;
        push(16'd2, HC, HC - DD, 1);
        push(16'd3, HC, HC - DD, 1);
        push(16'd4, HC, HC - DD, 1);
        wait_pulse(0, 20, "wait_fall_c2");
        wait_pulse(0, 20, "wait_fall_c3");
        step(1);
        run_en = 1'b0;
        wait_pulse(0, 20, "wait_fall_c4");
        check("halt_after_run_off", halted, 1);
        check("no_ack_after_run_off", step_ack, 0);
        step(5);
        check("halt_phi0_low", phi0, 0);
        check("halt_cycle_cnt", cycle_cnt, 4);

        // Single step: one full cycle, ack held while req is held, dropped the cycle after release
        push(16'd5, HC, HC - DD, 1);
        step_req = 1'b1;
        wait_pulse(0, 30, "wait_fall_step");
        check("step_ack_set", step_ack, 1);
        check("step_halted", halted, 1);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (phi0 || !step_ack || !halted) bad = 1'b1;
        end
        check("step_hold_no_second_pulse", bad, 0);
        step_req = 1'b0;
        step(1);
        check("step_ack_drop", step_ack, 0);

        // External clock: toggles every 6 eclk, ext_mode change ignored, run_en off halts at next fall
        push(16'd6, 6, 5, 1);
        push(16'd7, 6, 5, 1);
        push(16'd8, 6, 5, 1);
        push(16'd9, 6, 5, 1);
        for (int c = 0; c < 60; c++) begin
            if (c == 5)  check("ext_phi0_before_rise", phi0, 0);
            if (c == 6)  check("ext_phi0_one_late", phi0, 1);
            if (c == 11) check("ext_phi0_high_end", phi0, 1);
            if (c == 12) check("ext_phi0_low", phi0, 0);
            if (c == 30) check("ext_mode_change_ignored", phi0, 1);
            if (c == 50) begin
                check("ext_halted", halted, 1);
                check("ext_no_ack", step_ack, 0);
                check("ext_cycle_cnt", cycle_cnt, 9);
            end
            if (c == 0) begin
                run_en   = 1'b1;
                ext_mode = 1'b1;
            end
            if (c == 20) ext_mode = 1'b0;
            if (c == 38) run_en = 1'b0;
            if (c % 6 == 5) ext_clk0 = ~ext_clk0;
            step(1);
        end
        check("ext_halt_phi0_low", phi0, 0);

        // Reset during a step's PHI2 with db_oe active
        step_req = 1'b1;
        wait_pulse(1, 30, "wait_rise_reset");
        step(2);
        check("pre_reset_db_oe", db_oe, 1);
        check("pre_reset_phi0", phi0, 1);
        ereset_n = 1'b0;
        step_req = 1'b0;
        #1;
        check("async_rst_db_oe", db_oe, 0);
        check("async_rst_phi0", phi0, 0);
        check("async_rst_halted", halted, 0);
        check("async_rst_step_ack", step_ack, 0);
        check("async_rst_cycle_cnt", cycle_cnt, 0);
        step(2);
        ereset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (phi0 || step_ack || !halted) bad = 1'b1;
        end
        check("post_reset_step_lost", bad, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
